// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port data memory among NREQ PUs.
// Optional macro DMEM_ARB_LOCK_EN adds bounded locked grants for atomic read-modify-write.
module dmem_arbiter #(
    parameter int NREQ     = 2,
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    input  logic [NREQ-1:0]    lock_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rvalid_o,
    output logic [DW-1:0]      rdata_o,
    output logic               mem_en_o,
    output logic               mem_we_o,
    output logic [AW-1:0]      mem_addr_o,
    output logic [DW-1:0]      mem_wdata_o,
    input  logic [DW-1:0]      mem_rdata_i
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_s, win_nxt_s;
    logic [2*NREQ-1:0] req2_s;
    logic [NREQ-1:0]   rot_s;
    logic              found_s, grant_s;
    logic [NREQ-1:0]   rd_pend_q, rd_pend_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(NREQ - 1)) begin
            return '0;
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    // Rotate requests so that bit 0 is the PU currently holding priority.
    assign req2_s  = {req_i, req_i} >> ptr_q;
    assign rot_s   = req2_s[NREQ-1:0];
    assign found_s = |rot_s;
    assign grant_s = found_s & rst_ni;

    // Priority scan from ptr_q; descending loop so the lowest offset wins.
    always_comb begin
        win_s = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                if (int'(ptr_q) + k >= NREQ) begin
                    win_s = PW'(int'(ptr_q) + k - NREQ);
                end else begin
                    win_s = PW'(int'(ptr_q) + k);
                end
            end else begin
                win_s = win_s;
            end
        end
    end

    assign win_nxt_s = ptr_inc(win_s);

    // Grant and memory port drive; controls forced low while in reset.
    always_comb begin
        gnt_o       = '0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = addr_i[win_s*AW +: AW];
        mem_wdata_o = wdata_i[win_s*DW +: DW];
        if (grant_s) begin
            gnt_o[win_s] = 1'b1;
            mem_en_o     = 1'b1;
            mem_we_o     = we_i[win_s];
        end else begin
            gnt_o    = '0;
            mem_en_o = 1'b0;
            mem_we_o = 1'b0;
        end
    end

    assign rd_pend_d = gnt_o & ~we_i;
    assign rvalid_o  = rd_pend_q;
    assign rdata_o   = mem_rdata_i;

`ifdef DMEM_ARB_LOCK_EN
    localparam int LW = $clog2(MAX_LOCK + 1);

    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          locked_s;

    assign locked_s = (lcnt_q != '0);

    // Locked grants pin ptr to the owner; release after MAX_LOCK grants or when lock/req drops.
    always_comb begin
        ptr_d  = ptr_q;
        lcnt_d = lcnt_q;
        if (grant_s) begin
            if (lock_i[win_s] && (int'(lcnt_q) + 1 < MAX_LOCK)) begin
                ptr_d  = win_s;
                lcnt_d = lcnt_q + LW'(1'b1);
            end else begin
                ptr_d  = win_nxt_s;
                lcnt_d = '0;
            end
        end else if (locked_s) begin
            ptr_d  = ptr_inc(ptr_q);
            lcnt_d = '0;
        end else begin
            ptr_d  = ptr_q;
            lcnt_d = lcnt_q;
        end
    end

    // Lock counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lcnt_q <= '0;
        end else begin
            lcnt_q <= lcnt_d;
        end
    end
`else
    logic unused_lock_s;
    assign unused_lock_s = ^lock_i;

    // Pure round-robin: priority moves past the last winner.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_s) begin
            ptr_d = win_nxt_s;
        end else begin
            ptr_d = ptr_q;
        end
    end
`endif

    // Priority pointer and pending-read register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            rd_pend_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rd_pend_q <= rd_pend_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter: a queue-based reference model predicts every
// cycle's grant/memory access and every read response; a monitor compares on the falling edge.
module tb_dmem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 8;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req, we, lock, gnt, rvalid;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [DW-1:0]      rdata, mem_wdata, mem_rdata;
    logic               mem_en, mem_we;
    logic [AW-1:0]      mem_addr;

    dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .lock_i(lock), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: write-first array with 1-cycle read latency, plus preload port.
    logic [DW-1:0] mem [256];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] gnt;
        logic            en;
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
    } acc_t;

    typedef struct {
        int              due;
        logic [NREQ-1:0] pu;
        logic [DW-1:0]   data;
    } rd_t;

    acc_t acc_q[$];
    rd_t  rd_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    int            m_ptr;
    logic [DW-1:0] gold [256];
    bit            pu_act [NREQ];
    bit            pu_we  [NREQ];
    logic [AW-1:0] pu_addr[NREQ];
    logic [DW-1:0] pu_wd  [NREQ];
    bit            rnd_mode, refill_mode;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int i, input bit w, input int a, input logic [DW-1:0] d);
        pu_act[i]  = 1'b1;
        pu_we[i]   = w;
        pu_addr[i] = AW'(a);
        pu_wd[i]   = d;
    endtask

    task automatic new_random(input int i, input bit force_read);
        set_req(i, force_read ? 1'b0 : ($urandom_range(0, 2) == 0),
                $urandom_range(0, 15), $urandom);
    endtask

    // One clock cycle: drive inputs, predict the DUT response and queue it for the monitor.
    task automatic step(input bit rst_v);
        acc_t a;
        int   winner;
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            for (int i = 0; i < NREQ; i++)
                if (!pu_act[i] && $urandom_range(0, 2) == 0) new_random(i, 1'b0);
        end
        rst_n = rst_v;
        for (int i = 0; i < NREQ; i++) begin
            req[i]             = pu_act[i];
            we[i]              = pu_we[i];
            addr[i*AW +: AW]   = pu_addr[i];
            wdata[i*DW +: DW]  = pu_wd[i];
        end
        a.cyc = cyc; a.gnt = '0; a.en = 1'b0; a.we = 1'b0; a.addr = '0; a.wdata = '0;
        if (!rst_v) begin
            m_ptr = 0;
            rd_q.delete();
        end else begin
            winner = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (pu_act[(m_ptr + k) % NREQ]) begin
                    winner = (m_ptr + k) % NREQ;
                    break;
                end
            end
            if (winner >= 0) begin
                a.gnt[winner] = 1'b1;
                a.en    = 1'b1;
                a.we    = pu_we[winner];
                a.addr  = pu_addr[winner];
                a.wdata = pu_wd[winner];
                if (a.we) gold[a.addr] = a.wdata;
                else rd_q.push_back('{due: cyc + 1, pu: a.gnt, data: gold[a.addr]});
                m_ptr = (winner + 1) % NREQ;
                pu_act[winner] = 1'b0;
                if (refill_mode) new_random(winner, 1'b1);
                else if (rnd_mode && $urandom_range(0, 1) == 0) new_random(winner, 1'b0);
            end
        end
        acc_q.push_back(a);
        cyc++;
    endtask

    // Monitor: compare every cycle's outputs against the queued predictions.
    initial begin
        acc_t            a;
        rd_t             r;
        logic [NREQ-1:0] erv;
        forever begin
            @(negedge clk);
            if (acc_q.size() != 0) begin
                a = acc_q.pop_front();
                chk("gnt", 64'(gnt), 64'(a.gnt));
                chk("mem_en", 64'(mem_en), 64'(a.en));
                chk("mem_we", 64'(mem_we), 64'(a.we));
                if (a.en) chk("mem_addr", 64'(mem_addr), 64'(a.addr));
                if (a.en && a.we) chk("mem_wdata", 64'(mem_wdata), 64'(a.wdata));
                erv = '0;
                if (rd_q.size() != 0 && rd_q[0].due == a.cyc) begin
                    r   = rd_q.pop_front();
                    erv = r.pu;
                    chk("rdata", 64'(rdata), 64'(r.data));
                end
                chk("rvalid", 64'(rvalid), 64'(erv));
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        rnd_mode = 1'b0; refill_mode = 1'b0; m_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            pu_act[i] = 1'b0; pu_we[i] = 1'b0; pu_addr[i] = '0; pu_wd[i] = '0;
        end
        for (int i = 0; i < 256; i++) gold[i] = $urandom;
        gold[5] = 32'hFFFF_FFF9;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            pl_en = 1'b1; pl_addr = AW'(i); pl_data = gold[i];
        end
        @(posedge clk);
        #1;
        pl_en = 1'b0;

        // Reset holds controls low even with all PUs requesting
        for (int i = 0; i < NREQ; i++) set_req(i, i == 1, 7, 32'h1234_5678);
        step(1'b0); step(1'b0);
        for (int i = 0; i < NREQ; i++) pu_act[i] = 1'b0;
        step(1'b1);

        // Single read of a negative word
        set_req(0, 1'b0, 8'h05, '0);
        step(1'b1); step(1'b1);

        // Contention from reset: PU0/PU1 alternate
        step(1'b0);
        refill_mode = 1'b1;
        set_req(0, 1'b0, 3, '0);
        set_req(1, 1'b0, 9, '0);
        repeat (4) step(1'b1);
        refill_mode = 1'b0;
        repeat (3) step(1'b1);

        // Write then read of the same address on consecutive cycles
        set_req(1, 1'b1, 8'h10, 32'h0000_002A);
        step(1'b1);
        set_req(0, 1'b0, 8'h10, '0);
        step(1'b1); step(1'b1);

        // Idle, then a single request granted at once
        repeat (5) step(1'b1);
        set_req(2, 1'b0, 8'h05, '0);
        step(1'b1);

        // Reset the cycle after a read grant to PU1
        set_req(1, 1'b0, 8'h10, '0);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        set_req(0, 1'b0, 1, '0);
        set_req(1, 1'b0, 2, '0);
        step(1'b1); step(1'b1); step(1'b1);

        // Randomized traffic with back-to-back requests and hazards
        rnd_mode = 1'b1;
        repeat (3000) step(1'b1);
        rnd_mode = 1'b0;
        repeat (6) step(1'b1);

        @(negedge clk);
        #1;
        chk("acc_q_drained", 64'(acc_q.size()), 64'd0);
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
